// File: rtl/dtc_ctrl.sv
// DTC sequencing and gain-calibration controller: fractional accumulator, gain-scaled
// DTC code generation, and sign-sign LMS gain trim from the bang-bang phase detector.
module dtc_ctrl #(
  parameter int DIN_WIDTH  = 10,
  parameter int FRAC_WIDTH = 16,
  parameter int GAIN_WIDTH = 12,
  parameter int GAIN_INIT  = 2048,
  parameter int CAL_CYCLES = 1024,
  parameter int CAL_STEP   = 16,
  parameter int TRACK_STEP = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        recal,
  input  logic [FRAC_WIDTH-1:0]       frac_fcw,
  input  logic                        bbpd_valid,
  input  logic                        bbpd_early,
  output logic signed [DIN_WIDTH-1:0] d_in,
  output logic                        carry_out,
  output logic                        code_valid,
  output logic [GAIN_WIDTH-1:0]       gain_out,
  output logic                        cal_done,
  output logic [1:0]                  state_out
);

  localparam int PW    = FRAC_WIDTH + GAIN_WIDTH;
  localparam int SHIFT = PW - (DIN_WIDTH - 1);
  localparam int CW    = $clog2(CAL_CYCLES + 1);
  localparam logic [GAIN_WIDTH:0]       CSTEP = (GAIN_WIDTH+1)'(CAL_STEP);
  localparam logic [GAIN_WIDTH:0]       TSTEP = (GAIN_WIDTH+1)'(TRACK_STEP);
  localparam logic signed [DIN_WIDTH-1:0] D_OFS = DIN_WIDTH'(1 << (DIN_WIDTH - 2));

  typedef enum logic [1:0] {IDLE = 2'd0, CAL = 2'd1, TRACK = 2'd2} state_t;
  state_t state, state_nxt;

  logic [FRAC_WIDTH-1:0]  acc;
  logic [1:0]             hist;
  logic [CW-1:0]          cnt;

  logic                   run;
  logic [FRAC_WIDTH:0]    sum;
  logic [FRAC_WIDTH-1:0]  acc_nxt;
  logic [PW-1:0]          prod;
  logic [DIN_WIDTH-2:0]   code;
  logic                   upd;
  logic                   cal_hit;
  logic [GAIN_WIDTH:0]    step;
  logic [GAIN_WIDTH:0]    gain_up;
  logic [GAIN_WIDTH-1:0]  gain_inc;
  logic [GAIN_WIDTH-1:0]  gain_dec;

  assign run     = ((state == CAL) || (state == TRACK)) && en;
  assign sum     = {1'b0, acc} + {1'b0, frac_fcw};
  assign acc_nxt = sum[FRAC_WIDTH-1:0];
  // Full-width product keeps every bit until the final shift.
  assign prod    = PW'(acc_nxt) * PW'(gain_out);
  assign code    = prod[PW-1:SHIFT];

  // hist[1] holds the accumulator MSB of the code issued two edges ago.
  assign upd      = run && bbpd_valid && hist[1];
  assign cal_hit  = run && (state == CAL) && bbpd_valid && (cnt == CW'(CAL_CYCLES - 1));
  assign step     = (state == CAL) ? CSTEP : TSTEP;
  assign gain_up  = {1'b0, gain_out} + step;
  assign gain_inc = gain_up[GAIN_WIDTH] ? '1 : gain_up[GAIN_WIDTH-1:0];
  assign gain_dec = ({1'b0, gain_out} < step) ? '0 : (gain_out - step[GAIN_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = (cal_done && !recal) ? TRACK : CAL;
      CAL, TRACK: begin
        if (!en)         state_nxt = IDLE;
        else if (recal)  state_nxt = CAL;
        else if (cal_hit) state_nxt = TRACK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      hist       <= '0;
      cnt        <= '0;
      d_in       <= '0;
      carry_out  <= 1'b0;
      code_valid <= 1'b0;
      gain_out   <= GAIN_WIDTH'(GAIN_INIT);
      cal_done   <= 1'b0;
    end else if (run) begin
      acc        <= acc_nxt;
      carry_out  <= sum[FRAC_WIDTH];
      d_in       <= $signed({1'b0, code}) - D_OFS;
      code_valid <= 1'b1;
      hist       <= {hist[0], acc_nxt[FRAC_WIDTH-1]};
      if (upd) gain_out <= bbpd_early ? gain_inc : gain_dec;
      if (recal) begin
        cnt      <= '0;
        cal_done <= 1'b0;
      end else if (cal_hit) begin
        cnt      <= '0;
        cal_done <= 1'b1;
      end else if ((state == CAL) && bbpd_valid) begin
        cnt      <= cnt + CW'(1);
      end
    end else begin
      // Idle, or leaving a running state: outputs quiesce and history restarts.
      acc        <= '0;
      hist       <= '0;
      d_in       <= '0;
      carry_out  <= 1'b0;
      code_valid <= 1'b0;
      if (recal) cal_done <= 1'b0;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_dtc_ctrl.sv
// Directed bench for dtc_ctrl: a default instance and a short-calibration instance
// share stimulus; expected values are hand-computed.
module tb_dtc_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, recal, bbpd_valid, bbpd_early;
  logic [15:0] frac_fcw;

  logic signed [9:0] d0, d8;
  logic              c0, c8, v0, v8, cd0, cd8;
  logic [11:0]       g0, g8;
  logic [1:0]        s0, s8;

  int checks = 0;
  int errors = 0;

  dtc_ctrl u0 (
    .clk(clk), .rst(rst), .en(en), .recal(recal), .frac_fcw(frac_fcw),
    .bbpd_valid(bbpd_valid), .bbpd_early(bbpd_early),
    .d_in(d0), .carry_out(c0), .code_valid(v0), .gain_out(g0),
    .cal_done(cd0), .state_out(s0)
  );

  dtc_ctrl #(.CAL_CYCLES(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .recal(recal), .frac_fcw(frac_fcw),
    .bbpd_valid(bbpd_valid), .bbpd_early(bbpd_early),
    .d_in(d8), .carry_out(c8), .code_valid(v8), .gain_out(g8),
    .cal_done(cd8), .state_out(s8)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic v, input logic e);
    bbpd_valid = v;
    bbpd_early = e;
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int exp_d[4];
    exp_d[0] = -192; exp_d[1] = -128; exp_d[2] = -64; exp_d[3] = -256;

    rst = 1'b1; en = 1'b0; recal = 1'b0; frac_fcw = '0;
    bbpd_valid = 1'b0; bbpd_early = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_d_in", d0, 0);
    chk("rst_carry", c0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_gain", g0, 2048);
    chk("rst_cal_done", cd0, 0);
    chk("rst_state", s0, 0);
    chk("rst_gain8", g8, 2048);

    // Enable: one edge to leave IDLE, then a repeating code pattern.
    en = 1'b1; frac_fcw = 16'h4000;
    step();
    chk("en_state", s0, 1);
    chk("en_valid", v0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("seq_d_in", d0, exp_d[i % 4]);
      chk("seq_carry", c0, (i % 4 == 3) ? 1 : 0);
      chk("seq_valid", v0, 1);
    end

    // LMS in CAL: valid on running edges 3..102, MSB set on odd edges.
    en = 1'b0;
    step();
    chk("off_state", s0, 0);
    chk("off_d_in", d0, 0);
    chk("off_valid", v0, 0);
    en = 1'b1; frac_fcw = 16'h8000;
    step();
    chk("lms_state", s0, 1);
    for (int i = 1; i <= 102; i++) begin
      bbpd_valid = (i >= 3);
      bbpd_early = 1'b1;
      step();
    end
    bbpd_valid = 1'b0;
    chk("lms_gain", g0, 2848);
    step();
    chk("lms_d_in", d0, -78);
    chk("lms_carry0", c0, 0);
    step();
    chk("lms_d_wrap", d0, -256);
    chk("lms_carry1", c0, 1);

    // Upper saturation: 77 more updates reach 4080, next clamps at 4095.
    run(153, 1'b1, 1'b1);
    chk("sat_4080", g0, 4080);
    run(2, 1'b1, 1'b1);
    chk("sat_hi", g0, 4095);
    run(4, 1'b1, 1'b1);
    chk("sat_hi_hold", g0, 4095);
    // Lower saturation: 255 decrements reach 15, next clamps at 0.
    run(510, 1'b1, 1'b0);
    chk("sat_15", g0, 15);
    run(2, 1'b1, 1'b0);
    chk("sat_lo", g0, 0);
    run(4, 1'b1, 1'b0);
    chk("sat_lo_hold", g0, 0);
    chk("sat_still_cal", s0, 1);
    chk("sat_not_done", cd0, 0);

    // Reset mid-CAL, with en held high.
    bbpd_valid = 1'b0; rst = 1'b1;
    step();
    chk("rstcal_gain", g0, 2048);
    chk("rstcal_done", cd0, 0);
    chk("rstcal_state", s0, 0);
    chk("rstcal_d_in", d0, 0);
    rst = 1'b0;
    step();
    chk("cal8_enter", s8, 1);

    // Short calibration: 8 valid samples, updates at edges 3,5,7.
    run(7, 1'b1, 1'b1);
    chk("cal8_pre_state", s8, 1);
    chk("cal8_pre_done", cd8, 0);
    chk("cal8_pre_gain", g8, 2096);
    run(1, 1'b1, 1'b1);
    chk("cal8_done", cd8, 1);
    chk("cal8_track", s8, 2);
    chk("cal8_gain", g8, 2096);
    run(3, 1'b1, 1'b1);
    chk("track_gain", g8, 2104);
    chk("track_state", s8, 2);
    chk("cal1024_gain", g0, 2128);

    // Disable mid-TRACK, re-enable straight into TRACK with fresh history.
    bbpd_valid = 1'b0; en = 1'b0;
    step();
    chk("trk_off_state", s8, 0);
    chk("trk_off_d_in", d8, 0);
    chk("trk_off_gain", g8, 2104);
    chk("trk_off_done", cd8, 1);
    en = 1'b1;
    step();
    chk("reen_state", s8, 2);
    run(1, 1'b1, 1'b1);
    chk("reen_d_in", d8, -125);
    chk("reen_valid", v8, 1);
    run(1, 1'b1, 1'b1);
    chk("reen_gain_hold", g8, 2104);
    chk("reen_carry", c8, 1);
    run(1, 1'b1, 1'b1);
    chk("reen_gain_step", g8, 2108);

    // Recal pulse from TRACK.
    bbpd_valid = 1'b0; recal = 1'b1;
    step();
    recal = 1'b0;
    chk("recal_state", s8, 1);
    chk("recal_done", cd8, 0);
    chk("recal_gain", g8, 2108);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
